cursor_nav: RTL and testbench
=============================

Name: cursor_nav

Overview:
- Cursor navigation stage for the Buscaminas board.
- Turns four raw push-button inputs into a registered cell cursor (x, y). That cursor feeds the flag-selection and reveal stages directly downstream.
- Each input is synchronized and debounced, moves the cursor on its press edge, and auto-repeats while held.
- Edges either wrap or saturate, set by a parameter.

Parameters:
BOARD_W, 8, number of columns (2..16); x range 0..BOARD_W-1
BOARD_H, 8, number of rows (2..16); y range 0..BOARD_H-1
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to change a debounced level (>=1)
REPEAT_DELAY, 10, cycles a single held direction waits after its first move before auto-repeat begins (>=1)
REPEAT_PERIOD, 5, cycles between auto-repeat moves (>=1)
WRAP, 1, 1 = wrap at board edges, 0 = saturate at edges

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets)
btn_up  input  1  raw button, active-high, asynchronous to clk; decrements y
btn_down  input  1  raw button; increments y
btn_left  input  1  raw button; decrements x
btn_right  input  1  raw button; increments x
x  output  4  current cursor column, registered
y  output  4  current cursor row, registered
move_pulse  output  1  high for exactly one cycle on each cycle where x or y changed
held  output  1  high while any debounced button level is 1

Behaviour:
- Reset: on a rising edge with reset==0, clear the following: x=0, y=0, move_pulse=0, held=0, all synchronizer flops, debounced levels, debounce counters and repeat counter; FSM=IDLE. Reset takes priority over every other event, including mid-debounce and mid-repeat; nothing pending survives it.
- Synchronizer: two flops per button.
- Debounce, per button, independent:
  - A counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
- Press event: the debounced level rising 0->1.
  - Raw high sampled first at edge N gives debounced=1 after edge N+1+DEBOUNCE_CYCLES.
  - The cursor updates at edge N+2+DEBOUNCE_CYCLES.
  - Release (1->0) never moves the cursor.
- Move arithmetic:
  - up: y-1; down: y+1; left: x-1; right: x+1.
  - WRAP=1: 0-1 -> max, max+1 -> 0 (max = BOARD_W-1 or BOARD_H-1).
  - WRAP=0: value is held at the bound; the blocked axis does not count as a change.
- Simultaneous press events in the same cycle:
  - The x and y axes are applied independently in that cycle.
  - up+down in the same cycle cancel (no y change); left+right cancel (no x change).
- move_pulse: registered alongside x/y; equals 1 in the cycle after an edge where x or y actually changed value, otherwise 0.
- Auto-repeat FSM:
  - IDLE: enter DELAY when a press event occurs while exactly one debounced level is 1; load the counter with REPEAT_DELAY.
  - DELAY: decrement each cycle; at 0, perform one move of the held direction, load REPEAT_PERIOD, go to REPEAT.
  - REPEAT: decrement each cycle; at 0, move and reload REPEAT_PERIOD.
  - From DELAY or REPEAT, go to IDLE the cycle the set of debounced levels changes: a release, or an additional press. An additional press still applies its own press-event move.
  - Two or more buttons held means no auto-repeat.
- Counters are sized for max(REPEAT_DELAY, REPEAT_PERIOD, DEBOUNCE_CYCLES).
- held = OR of the four debounced levels, registered.
- x and y are always within range; out-of-range values are never produced.

Test Plan:
(defaults BOARD 8x8, DEBOUNCE 4, REPEAT_DELAY 10, REPEAT_PERIOD 5, WRAP=1)
1. Reset then idle: reset=0 for 2 cycles -> x=0, y=0, move_pulse=0, held=0. Release reset -> values hold with no inputs.
2. Debounce latency: btn_right sampled high first at edge 0 and held for 8 cycles -> x becomes 1 after edge 6, move_pulse=1 for exactly that cycle. A glitch high for 3 cycles -> no change.
3. Wrap: from x=0, press left -> x=7. From y=7, press down -> y=0. With WRAP=0, x=0 plus left -> x=0 and move_pulse stays 0.
4. Auto-repeat: hold btn_down for 40 cycles after debounce from y=0 -> y=1 on the press edge, y=2 at +10 cycles, then +1 every 5 cycles. Release -> no further change.
5. Simultaneous: up and down debounced in the same cycle -> y unchanged. Right and down in the same cycle -> x+1, y+1, single move_pulse, no auto-repeat.
6. Reset mid-repeat: assert reset=0 during REPEAT with the button still held -> x=y=0 next cycle. After reset releases, the button must pass debounce again before the next move.

Source files
------------

// File: rtl/cursor_nav_if.sv
// Button inputs and cursor outputs of the cursor navigation stage.
// The slave side is the cursor_nav block; the master side is whatever drives it.
interface cursor_nav_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic [3:0] x;
   logic [3:0] y;
   logic       move_pulse;
   logic       held;

   modport master (
      output btn_up, btn_down, btn_left, btn_right,
      input  x, y, move_pulse, held
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right,
      output x, y, move_pulse, held
   );
endinterface

// File: rtl/cursor_nav.sv
// Cursor navigation: four raw buttons are synchronized, debounced and turned into
// a registered board cursor, with press-edge moves and single-button auto-repeat.
module cursor_nav #(
   parameter int BOARD_W         = 8,
   parameter int BOARD_H         = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 10,
   parameter int REPEAT_PERIOD   = 5,
   parameter int WRAP            = 1
) (
   input  logic          clk,
   input  logic          reset,
   cursor_nav_if.slave   bus
);
   localparam int MAX_RP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int MAX_C  = (MAX_RP > DEBOUNCE_CYCLES) ? MAX_RP : DEBOUNCE_CYCLES;
   localparam int CW     = $clog2(MAX_C + 1);
   localparam logic [3:0] X_MAX = 4'(BOARD_W - 1);
   localparam logic [3:0] Y_MAX = 4'(BOARD_H - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2
   } state_t;

   // Button bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right.
   logic [3:0]          raw_s;
   logic [3:0]          sync1_q, sync2_q;
   logic [3:0]          deb_q, deb_d, prev_q;
   logic [3:0][CW-1:0]  db_cnt_q, db_cnt_d;
   logic [CW-1:0]       rpt_cnt_q, rpt_cnt_d;
   state_t              state_q, state_d;
   logic [3:0]          x_q, x_d, y_q, y_d;
   logic                move_pulse_q, move_pulse_d;
   logic                held_q, held_d;
   logic [3:0]          press_s, mv_s;
   logic                changed_s, one_hot_s, fire_s;

   function automatic logic [3:0] step_inc(input logic [3:0] v, input logic [3:0] max_v);
      logic [3:0] r;
      if (v >= max_v) begin
         r = (WRAP != 0) ? 4'd0 : max_v;
      end else begin
         r = v + 4'd1;
      end
      return r;
   endfunction

   function automatic logic [3:0] step_dec(input logic [3:0] v, input logic [3:0] max_v);
      logic [3:0] r;
      if (v == 4'd0) begin
         r = (WRAP != 0) ? max_v : 4'd0;
      end else begin
         r = v - 4'd1;
      end
      return r;
   endfunction

   assign raw_s = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

   // Per-button debounce: a level flips only after DEBOUNCE_CYCLES disagreeing samples.
   always_comb begin
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] >= CW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i]    = ~deb_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + CW'(1);
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
   end

   assign press_s   = deb_q & ~prev_q;
   assign changed_s = (deb_q != prev_q);
   assign one_hot_s = (deb_q != 4'd0) && ((deb_q & (deb_q - 4'd1)) == 4'd0);

   // Auto-repeat sequencing; any change in the held set cancels it.
   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      fire_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((press_s != 4'd0) && one_hot_s) begin
               state_d   = ST_DELAY;
               rpt_cnt_d = CW'(REPEAT_DELAY);
            end else begin
               rpt_cnt_d = '0;
            end
         end
         ST_DELAY, ST_REPEAT: begin
            if (changed_s) begin
               state_d   = ST_IDLE;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q <= CW'(1)) begin
               fire_s    = 1'b1;
               state_d   = ST_REPEAT;
               rpt_cnt_d = CW'(REPEAT_PERIOD);
            end else begin
               rpt_cnt_d = rpt_cnt_q - CW'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
         end
      endcase
   end

   assign mv_s = press_s | (fire_s ? deb_q : 4'd0);

   // Axis updates are independent; opposite directions in one cycle cancel.
   always_comb begin
      case (mv_s[1:0])
         2'b01:   y_d = step_dec(y_q, Y_MAX);
         2'b10:   y_d = step_inc(y_q, Y_MAX);
         default: y_d = y_q;
      endcase
      case (mv_s[3:2])
         2'b01:   x_d = step_dec(x_q, X_MAX);
         2'b10:   x_d = step_inc(x_q, X_MAX);
         default: x_d = x_q;
      endcase
      move_pulse_d = (x_d != x_q) || (y_d != y_q);
      held_d       = |deb_q;
   end

   // All state, with synchronous active-low reset taking priority.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q      <= 4'd0;
         sync2_q      <= 4'd0;
         deb_q        <= 4'd0;
         prev_q       <= 4'd0;
         db_cnt_q     <= '0;
         rpt_cnt_q    <= '0;
         state_q      <= ST_IDLE;
         x_q          <= 4'd0;
         y_q          <= 4'd0;
         move_pulse_q <= 1'b0;
         held_q       <= 1'b0;
      end else begin
         sync1_q      <= raw_s;
         sync2_q      <= sync1_q;
         deb_q        <= deb_d;
         prev_q       <= deb_q;
         db_cnt_q     <= db_cnt_d;
         rpt_cnt_q    <= rpt_cnt_d;
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         move_pulse_q <= move_pulse_d;
         held_q       <= held_d;
      end
   end

   assign bus.x          = x_q;
   assign bus.y          = y_q;
   assign bus.move_pulse = move_pulse_q;
   assign bus.held       = held_q;
endmodule

// File: tb/tb_cursor_nav.sv
// Directed bench for cursor_nav: a wrapping instance and a saturating instance
// share clock and reset; inputs change and outputs are sampled on the falling edge.
module tb_cursor_nav;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   cursor_nav_if bus ();
   cursor_nav_if bus_s ();

   cursor_nav #(.WRAP(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   cursor_nav #(.WRAP(0)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // idx: 0=up 1=down 2=left 3=right; alt selects the saturating instance.
   task automatic set_btn(input bit alt, input int idx, input logic v);
      if (!alt) begin
         case (idx)
            0: bus.btn_up    = v;
            1: bus.btn_down  = v;
            2: bus.btn_left  = v;
            default: bus.btn_right = v;
         endcase
      end else begin
         case (idx)
            0: bus_s.btn_up    = v;
            1: bus_s.btn_down  = v;
            2: bus_s.btn_left  = v;
            default: bus_s.btn_right = v;
         endcase
      end
   endtask

   // Press: raw high from edge 0; cursor moves at edge 6; returns just after edge 6.
   task automatic tap(input bit alt, input int idx);
      set_btn(alt, idx, 1'b1);
      cycles(7);
   endtask

   // Release and let the debounced level fall and the repeat FSM settle.
   task automatic untap(input bit alt, input int idx);
      set_btn(alt, idx, 1'b0);
      cycles(12);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_btn(1'b0, i, 1'b0);
         set_btn(1'b1, i, 1'b0);
      end

      // 1. reset then idle
      cycles(2);
      check("rst_x", bus.x, 8'd0);
      check("rst_y", bus.y, 8'd0);
      check("rst_mp", bus.move_pulse, 8'd0);
      check("rst_held", bus.held, 8'd0);
      check("rst_x_sat", bus_s.x, 8'd0);
      reset = 1'b1;
      cycles(5);
      check("idle_x", bus.x, 8'd0);
      check("idle_y", bus.y, 8'd0);
      check("idle_mp", bus.move_pulse, 8'd0);

      // 2. debounce latency, held 8 cycles
      set_btn(1'b0, 3, 1'b1);
      cycles(6);
      check("lat_x_e5", bus.x, 8'd0);
      check("lat_held_e5", bus.held, 8'd0);
      cycles(1);
      check("lat_x_e6", bus.x, 8'd1);
      check("lat_mp_e6", bus.move_pulse, 8'd1);
      check("lat_held_e6", bus.held, 8'd1);
      cycles(1);
      check("lat_mp_e7", bus.move_pulse, 8'd0);
      set_btn(1'b0, 3, 1'b0);
      cycles(15);
      check("lat_x_after", bus.x, 8'd1);
      check("lat_held_after", bus.held, 8'd0);

      // 2b. 3-cycle glitch is rejected
      set_btn(1'b0, 2, 1'b1);
      cycles(3);
      set_btn(1'b0, 2, 1'b0);
      cycles(10);
      check("glitch_x", bus.x, 8'd1);
      check("glitch_held", bus.held, 8'd0);

      // 3. wrap at edges
      tap(1'b0, 2);
      check("left_x0", bus.x, 8'd0);
      untap(1'b0, 2);
      tap(1'b0, 2);
      check("wrap_left_x", bus.x, 8'd7);
      check("wrap_left_mp", bus.move_pulse, 8'd1);
      untap(1'b0, 2);
      tap(1'b0, 0);
      check("wrap_up_y", bus.y, 8'd7);
      untap(1'b0, 0);
      tap(1'b0, 1);
      check("wrap_down_y", bus.y, 8'd0);
      check("wrap_down_mp", bus.move_pulse, 8'd1);
      untap(1'b0, 1);

      // 3b. saturation instance blocks at 0
      tap(1'b1, 2);
      check("sat_left_x", bus_s.x, 8'd0);
      check("sat_left_mp", bus_s.move_pulse, 8'd0);
      check("sat_left_held", bus_s.held, 8'd1);
      untap(1'b1, 2);
      tap(1'b1, 0);
      check("sat_up_y", bus_s.y, 8'd0);
      check("sat_up_mp", bus_s.move_pulse, 8'd0);
      untap(1'b1, 0);
      tap(1'b1, 3);
      check("sat_right_x", bus_s.x, 8'd1);
      untap(1'b1, 3);

      // 4. auto-repeat on down from y=0 (x=7)
      tap(1'b0, 1);
      check("rpt_press_y", bus.y, 8'd1);
      cycles(9);
      check("rpt_e15_y", bus.y, 8'd1);
      cycles(1);
      check("rpt_e16_y", bus.y, 8'd2);
      check("rpt_e16_mp", bus.move_pulse, 8'd1);
      cycles(1);
      check("rpt_e17_mp", bus.move_pulse, 8'd0);
      cycles(3);
      check("rpt_e20_y", bus.y, 8'd2);
      cycles(1);
      check("rpt_e21_y", bus.y, 8'd3);
      cycles(20);
      check("rpt_e41_y", bus.y, 8'd7);
      cycles(5);
      check("rpt_e46_y", bus.y, 8'd0);
      set_btn(1'b0, 1, 1'b0);
      cycles(5);
      check("rpt_e51_y", bus.y, 8'd1);
      cycles(20);
      check("rpt_rel_y", bus.y, 8'd1);
      check("rpt_rel_mp", bus.move_pulse, 8'd0);
      check("rpt_rel_x", bus.x, 8'd7);

      // 5. simultaneous presses
      set_btn(1'b0, 0, 1'b1);
      set_btn(1'b0, 1, 1'b1);
      cycles(7);
      check("ud_y", bus.y, 8'd1);
      check("ud_mp", bus.move_pulse, 8'd0);
      check("ud_held", bus.held, 8'd1);
      cycles(15);
      check("ud_norpt_y", bus.y, 8'd1);
      set_btn(1'b0, 0, 1'b0);
      set_btn(1'b0, 1, 1'b0);
      cycles(12);
      set_btn(1'b0, 3, 1'b1);
      set_btn(1'b0, 1, 1'b1);
      cycles(7);
      check("rd_x", bus.x, 8'd0);
      check("rd_y", bus.y, 8'd2);
      check("rd_mp", bus.move_pulse, 8'd1);
      cycles(1);
      check("rd_mp_next", bus.move_pulse, 8'd0);
      cycles(20);
      check("rd_norpt_x", bus.x, 8'd0);
      check("rd_norpt_y", bus.y, 8'd2);
      set_btn(1'b0, 3, 1'b0);
      set_btn(1'b0, 1, 1'b0);
      cycles(12);

      // 6. reset mid-repeat with the button still held
      set_btn(1'b0, 3, 1'b1);
      cycles(23);
      check("mid_x_e22", bus.x, 8'd3);
      reset = 1'b0;
      cycles(1);
      check("mid_rst_x", bus.x, 8'd0);
      check("mid_rst_y", bus.y, 8'd0);
      check("mid_rst_mp", bus.move_pulse, 8'd0);
      check("mid_rst_held", bus.held, 8'd0);
      reset = 1'b1;
      cycles(6);
      check("redeb_x_e29", bus.x, 8'd0);
      check("redeb_held_e29", bus.held, 8'd0);
      cycles(1);
      check("redeb_x_e30", bus.x, 8'd1);
      check("redeb_mp_e30", bus.move_pulse, 8'd1);
      set_btn(1'b0, 3, 1'b0);
      cycles(15);
      check("redeb_rel_x", bus.x, 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
